// File: rtl/frame_reader.sv
// ---------------------------------------------------------------------------
// frame_reader
//
// Read side of the pixel framebuffer. Generates VGA raster timing (640x480
// by default), issues one framebuffer read per visible pixel, registers the
// returned colour and drives RGB, sync and display-enable to the DAC. The
// screen-clear sweep on the write side may hold 'blank' to force black.
//
// Ports
//   clk         in   1        system clock
//   reset_n     in   1        asynchronous, active-low reset
//   pix_en      in   1        pixel tick, one clk wide, never on consecutive clks
//   start       in   1        pulse: begin scanning frames
//   stop        in   1        pulse: stop once the current frame completes
//   blank       in   1        force black output, sampled per pixel
//   rd_req      out  1        framebuffer read strobe (combinational)
//   rd_x        out  11       read column, 0 while idle
//   rd_y        out  11       read row, 0 while idle
//   rd_data     in   COLOR_W  colour word, valid exactly 1 clk after rd_req
//   rgb         out  COLOR_W  pixel colour to DAC
//   hsync_n     out  1        active-low horizontal sync
//   vsync_n     out  1        active-low vertical sync
//   de          out  1        display enable (visible pixel)
//   frame_done  out  1        1-clk pulse on the tick that wraps the raster
//   busy        out  1        high while scanning
// ---------------------------------------------------------------------------
module frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_en,
    input  logic               start,
    input  logic               stop,
    input  logic               blank,
    output logic               rd_req,
    output logic [10:0]        rd_x,
    output logic [10:0]        rd_y,
    input  logic [COLOR_W-1:0] rd_data,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               de,
    output logic               frame_done,
    output logic               busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [10:0]          h_q, h_d;
    logic [10:0]          v_q, v_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 de_q, de_d;
    logic                 hs_n_q, hs_n_d;
    logic                 vs_n_q, vs_n_d;
    logic [COLOR_W-1:0]   rgb_q, rgb_d;
    logic                 cap_q, cap_d;

    logic                 in_active;
    logic                 at_wrap;
    logic                 tick;

    // Raster position decode on the current (pre-increment) counters.
    assign in_active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign at_wrap   = (h_q == H_LAST) && (v_q == V_LAST);

    assign busy       = (state_q == ST_SCAN);
    assign tick       = busy & pix_en;
    assign rd_req     = tick & in_active;
    assign rd_x       = busy ? h_q : 11'd0;
    assign rd_y       = busy ? v_q : 11'd0;
    assign frame_done = tick & at_wrap;

    assign de      = de_q;
    assign hsync_n = hs_n_q;
    assign vsync_n = vs_n_q;
    assign rgb     = rgb_q;

    // ---- Control: scan FSM and raster counters -----------------------------
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            ST_IDLE: begin
                h_d         = 11'd0;
                v_d         = 11'd0;
                stop_pend_d = 1'b0;
                if (start) begin
                    state_d     = ST_SCAN;
                    // start+stop together scans exactly one frame.
                    stop_pend_d = stop;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (pix_en) begin
                    if (h_q == H_LAST) begin
                        h_d = 11'd0;
                        if (v_q == V_LAST) begin
                            v_d = 11'd0;
                            // Only a stop seen before the wrap tick ends
                            // this frame; one arriving on it waits a frame.
                            if (stop_pend_q) begin
                                state_d     = ST_IDLE;
                                stop_pend_d = 1'b0;
                            end
                        end else begin
                            v_d = v_q + 11'd1;
                        end
                    end else begin
                        h_d = h_q + 11'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- Timing stage: de/sync registered on the pixel tick ---------------
    always_comb begin
        de_d   = de_q;
        hs_n_d = hs_n_q;
        vs_n_d = vs_n_q;

        if (!busy) begin
            de_d   = 1'b0;
            hs_n_d = 1'b1;
            vs_n_d = 1'b1;
        end else if (pix_en) begin
            de_d   = in_active;
            hs_n_d = ~((h_q >= HS_FIRST) && (h_q <= HS_LAST));
            vs_n_d = ~((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        end
    end

    // ---- Colour stage: capture rd_data the clk after rd_req ---------------
    // pix_en is never on consecutive clks, so the capture clk can never
    // coincide with the next pixel tick.
    always_comb begin
        rgb_d = rgb_q;
        cap_d = rd_req;

        if (cap_q) begin
            rgb_d = blank ? '0 : rd_data;
        end else if (!busy || (pix_en && !in_active)) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            h_q         <= 11'd0;
            v_q         <= 11'd0;
            stop_pend_q <= 1'b0;
            de_q        <= 1'b0;
            hs_n_q      <= 1'b1;
            vs_n_q      <= 1'b1;
            rgb_q       <= '0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            stop_pend_q <= stop_pend_d;
            de_q        <= de_d;
            hs_n_q      <= hs_n_d;
            vs_n_q      <= vs_n_d;
            rgb_q       <= rgb_d;
            cap_q       <= cap_d;
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;

    // Reduced raster so several whole frames fit in a short run.
    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VA = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int CW = 12;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pix_en;
    logic          start;
    logic          stop;
    logic          blank;
    logic          rd_req;
    logic [10:0]   rd_x;
    logic [10:0]   rd_y;
    logic [CW-1:0] rd_data;
    logic [CW-1:0] rgb;
    logic          hsync_n;
    logic          vsync_n;
    logic          de;
    logic          frame_done;
    logic          busy;

    frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .COLOR_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .start(start),
        .stop(stop), .blank(blank), .rd_req(rd_req), .rd_x(rd_x),
        .rd_y(rd_y), .rd_data(rd_data), .rgb(rgb), .hsync_n(hsync_n),
        .vsync_n(vsync_n), .de(de), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raster position as a linear pixel index in the frame.
    bit          m_scan = 0;
    bit          m_stop_pend = 0;
    int          m_p = 0;
    bit          m_de = 0;
    bit          m_hs_n = 1;
    bit          m_vs_n = 1;
    logic [CW-1:0] m_rgb = '0;
    bit          m_pend = 0;
    int          m_px = 0;
    int          m_py = 0;

    // Framebuffer model answering the DUT's reads.
    bit mem_pend = 0;
    int mem_x = 0;
    int mem_y = 0;

    // Aggregate monitors on observed outputs.
    int   tick_cnt = 0;
    int   req_cnt = 0;
    int   fd_cnt = 0;
    bit   first_pend = 1;
    int   hs_run = 0;
    int   vs_run = 0;
    int   de_run = 0;
    logic hs_prev = 1'b1;
    logic vs_prev = 1'b1;
    logic de_prev = 1'b0;

    // Stimulus controls.
    bit last_pe = 0;
    bit fixed2 = 0;
    int blank_mode = 0;

    function automatic logic [CW-1:0] color(input int x, input int y);
        logic [3:0] xs;
        logic [3:0] ys;
        xs = x[3:0];
        ys = y[3:0];
        return {xs, ys, 4'hA};
    endfunction

    task automatic monitor(input bit pe);
        if (!busy) begin
            tick_cnt   = 0;
            req_cnt    = 0;
            first_pend = 1;
        end else begin
            if (pe) tick_cnt++;
            if (rd_req) begin
                req_cnt++;
                if (first_pend) begin
                    chk("first_rd_x", 32'(rd_x), 32'd0);
                    chk("first_rd_y", 32'(rd_y), 32'd0);
                    first_pend = 0;
                end
            end
        end
        if (frame_done) begin
            fd_cnt++;
            chk("ticks_per_frame", 32'(tick_cnt), 32'(FRAME));
            chk("reqs_per_frame", 32'(req_cnt), 32'(HA * VA));
            tick_cnt = 0;
            req_cnt  = 0;
        end
        if (pe && hsync_n === 1'b0) hs_run++;
        if (pe && vsync_n === 1'b0) vs_run++;
        if (pe && de === 1'b1) de_run++;
        if (hs_prev === 1'b0 && hsync_n === 1'b1) begin
            chk("hsync_len", 32'(hs_run), 32'(HS));
            hs_run = 0;
        end
        if (vs_prev === 1'b0 && vsync_n === 1'b1) begin
            chk("vsync_len", 32'(vs_run), 32'(VS * HT));
            vs_run = 0;
        end
        if (de_prev === 1'b1 && de === 1'b0) begin
            chk("de_len", 32'(de_run), 32'(HA));
            de_run = 0;
        end
        hs_prev = hsync_n;
        vs_prev = vsync_n;
        de_prev = de;
    endtask

    task automatic cycle(input bit st, input bit sp);
        bit   pe;
        bit   bl;
        bit   act;
        bit   exp_req;
        int   h;
        int   v;
        @(negedge clk);
        h = m_p % HT;
        v = m_p / HT;
        if (last_pe || st || sp) pe = 1'b0;
        else if (fixed2)         pe = 1'b1;
        else                     pe = ($urandom_range(0, 2) != 0);
        case (blank_mode)
            0:       bl = 1'b0;
            1:       bl = (v == 3 || v == 4);
            default: bl = ($urandom_range(0, 1) == 1);
        endcase
        pix_en  = pe;
        start   = st;
        stop    = sp;
        blank   = bl;
        rd_data = mem_pend ? color(mem_x, mem_y) : CW'($urandom);
        #1;
        act     = m_scan && (h < HA) && (v < VA);
        exp_req = act && pe;
        chk("busy", 32'(busy), 32'(m_scan));
        chk("rd_req", 32'(rd_req), 32'(exp_req));
        chk("rd_x", 32'(rd_x), m_scan ? 32'(h) : 32'd0);
        chk("rd_y", 32'(rd_y), m_scan ? 32'(v) : 32'd0);
        chk("frame_done", 32'(frame_done), 32'(m_scan && pe && (m_p == FRAME - 1)));
        chk("de", 32'(de), 32'(m_de));
        chk("hsync_n", 32'(hsync_n), 32'(m_hs_n));
        chk("vsync_n", 32'(vsync_n), 32'(m_vs_n));
        chk("rgb", 32'(rgb), 32'(m_rgb));
        mem_pend = (rd_req === 1'b1);
        mem_x    = int'(rd_x);
        mem_y    = int'(rd_y);
        monitor(pe);

        // Expected register contents after the coming clk edge.
        if (m_pend)                      m_rgb = bl ? '0 : color(m_px, m_py);
        else if (!m_scan || (pe && !act)) m_rgb = '0;
        m_pend = exp_req;
        m_px   = h;
        m_py   = v;
        if (!m_scan) begin
            m_de   = 0;
            m_hs_n = 1;
            m_vs_n = 1;
        end else if (pe) begin
            m_de   = act;
            m_hs_n = !(h >= HA + HF && h < HA + HF + HS);
            m_vs_n = !(v >= VA + VF && v < VA + VF + VS);
        end
        if (!m_scan) begin
            if (st) begin
                m_scan      = 1;
                m_stop_pend = sp;
                m_p         = 0;
            end
        end else begin
            if (sp) m_stop_pend = 1;
            if (pe) begin
                if (m_p == FRAME - 1) begin
                    m_p = 0;
                    if (m_stop_pend) begin
                        m_scan      = 0;
                        m_stop_pend = 0;
                    end
                end else begin
                    m_p++;
                end
            end
        end
        last_pe = pe;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_x", 32'(rd_x), 32'd0);
        chk("rst_rd_y", 32'(rd_y), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hsync_n", 32'(hsync_n), 32'd1);
        chk("rst_vsync_n", 32'(vsync_n), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    task automatic model_reset();
        m_scan = 0; m_stop_pend = 0; m_p = 0; m_pend = 0;
        m_de = 0; m_hs_n = 1; m_vs_n = 1; m_rgb = '0;
        mem_pend = 0; last_pe = 0;
        hs_run = 0; vs_run = 0; de_run = 0;
        hs_prev = 1'b1; vs_prev = 1'b1; de_prev = 1'b0;
    endtask

    task automatic run_frames(input int n);
        int target;
        target = fd_cnt + n;
        for (int i = 0; i < 20000 && fd_cnt < target; i++) cycle(0, 0);
        chk("frames_reached", 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 5000 && !(m_scan && m_p == v * HT + h); i++) cycle(0, 0);
    endtask

    task automatic run_until_idle();
        cycle(0, 0);
        for (int i = 0; i < 5000 && busy === 1'b1; i++) cycle(0, 0);
        chk("scan_completes", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_before;
        reset_n = 1'b0;
        pix_en  = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        blank   = 1'b0;
        rd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;

        // Idle: stop is ignored, counters stay at zero.
        for (int i = 0; i < 20; i++) cycle(0, (i == 5 || i == 12));

        // Steady pix_en every 2nd clk, two whole frames.
        fixed2 = 1;
        cycle(1, 0);
        run_frames(2);

        // Blank on lines 3..4, irregular pixel ticks.
        fixed2 = 0;
        blank_mode = 1;
        run_frames(1);

        // Random per-pixel blank; a start while scanning must be ignored.
        blank_mode = 2;
        run_to(5, 1);
        cycle(1, 0);
        run_frames(1);

        // Stop mid-frame: the frame finishes, then reads cease.
        blank_mode = 0;
        run_to(10, 2);
        fd_before = fd_cnt;
        cycle(0, 1);
        run_until_idle();
        chk("stop_frames", 32'(fd_cnt - fd_before), 32'd1);
        for (int i = 0; i < 40; i++) cycle(0, 0);

        // start+stop together: exactly one frame.
        fd_before = fd_cnt;
        cycle(1, 1);
        run_until_idle();
        for (int i = 0; i < 40; i++) cycle(0, 0);
        chk("one_shot_frames", 32'(fd_cnt - fd_before), 32'd1);

        // Asynchronous reset mid-frame while a read is being issued.
        cycle(1, 0);
        run_to(8, 4);
        @(negedge clk);
        pix_en = !last_pe;
        start  = 1'b0;
        stop   = 1'b0;
        blank  = 1'b0;
        #1;
        chk("pre_reset_rd_req", 32'(rd_req), 32'(pix_en));
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        pix_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;
        model_reset();

        // Recovery after reset.
        blank_mode = 2;
        cycle(1, 0);
        run_frames(1);
        for (int i = 0; i < 20; i++) cycle(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
